dmem_responder: RTL and testbench
=================================

DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 Parameter DEPTH_WORDS, default 1024: number of 32-bit words in the backing array; byte address range is 0 to 4*DEPTH_WORDS-1.
REQ-002 Parameter LATENCY, default 1, legal range 1..15: cycles from request acceptance to first rsp_valid.
REQ-003 Clocking: one clock; reset is synchronous and active-high.
REQ-004 clk  in  1  clock; all state updates on rising edge.
REQ-005 reset  in  1  synchronous active-high reset.
REQ-006 req_valid  in  1  initiator presents a request.
REQ-007 req_ready  out  1  responder accepts a request this cycle.
REQ-008 req_we  in  1  1 = store, 0 = load.
REQ-009 req_funct3  in  3  RISC-V load/store funct3 (size and sign).
REQ-010 req_addr  in  32  byte address.
REQ-011 req_wdata  in  32  store data, right-aligned.
REQ-012 rsp_valid  out  1  response available.
REQ-013 rsp_ready  in  1  initiator consumes the response.
REQ-014 rsp_rdata  out  32  load result, extended to 32 bits; 0 for stores and errors.
REQ-015 rsp_err  out  1  request was misaligned, out of range, or had an illegal funct3.

Function
REQ-016 The FSM SHALL have three states: IDLE, WAIT and RESP; req_ready = 1 only in IDLE; rsp_valid = 1 only in RESP.
REQ-017 Acceptance SHALL occur on a rising edge with state IDLE and req_valid = 1; the request fields SHALL be captured at that edge.
REQ-018 After acceptance, state SHALL go to WAIT when LATENCY > 1 and to RESP when LATENCY = 1; WAIT SHALL last LATENCY-1 cycles (down-counter); rsp_valid SHALL first be high exactly LATENCY cycles after the acceptance edge.
REQ-019 Only one request SHALL be outstanding at a time; req_valid in WAIT/RESP SHALL be ignored.
REQ-020 In RESP, rsp_rdata and rsp_err SHALL hold stable until the edge where rsp_ready = 1; state SHALL then return to IDLE; req_ready SHALL be 1 in the following cycle.
REQ-021 Loads: 000 LB sign-extends the byte at addr[1:0]; 100 LBU zero-extends it; 001 LH and 101 LHU select the halfword at addr[1] and sign- or zero-extend it; 010 LW returns the full word. The array is little-endian.
REQ-022 Stores: 000 SB writes req_wdata[7:0] to byte addr[1:0]; 001 SH writes req_wdata[15:0] to halfword addr[1]; 010 SW writes the full word. Other bytes SHALL be preserved.
REQ-023 A store SHALL commit to the array on its acceptance edge; a load SHALL sample the array on its acceptance edge, so a load issued after a store returns the new data.
REQ-024 Error cases: halfword access with addr[0] = 1; word access with addr[1:0] != 0; req_addr >= 4*DEPTH_WORDS; a load funct3 outside {000,001,010,100,101}; a store funct3 outside {000,001,010}.
REQ-025 An erroring request SHALL NOT modify the array, SHALL respond with rsp_err = 1 and rsp_rdata = 0, and SHALL follow the same latency as a good request.
REQ-026 The word index SHALL be req_addr[log2(4*DEPTH_WORDS)-1:2]; the range check in REQ-024 SHALL use the full 32-bit address, so addresses do not alias.

Reset
REQ-027 While reset = 1: state = IDLE, wait counter = 0, rsp_valid = 0, rsp_err = 0, rsp_rdata = 0; req_ready = 0 during the reset cycle and 1 on the first cycle after it.
REQ-028 Reset SHALL take priority over acceptance in the same cycle: no capture and no store commit.
REQ-029 Reset during WAIT or RESP SHALL drop the pending response; a store already committed SHALL remain in the array.
REQ-030 Array contents SHALL NOT be cleared by reset.

Verification
REQ-031 LATENCY=1: SW 0xDEADBEEF at 0x10, then LW 0x10 -> rsp_valid one cycle after each acceptance; load rsp_rdata = 0xDEADBEEF, rsp_err = 0.
REQ-032 After REQ-031: SB 0x7F at 0x11, then LB 0x13 -> 0xFFFFFFDE; LBU 0x13 -> 0x000000DE; LH 0x10 -> 0x00007FEF; LW 0x10 -> 0xDEAD7FEF.
REQ-033 LW at 0x12, SH at 0x11, LW at 0x1000 (DEPTH_WORDS=1024), funct3 = 011 -> rsp_err = 1 and rsp_rdata = 0 for each; a later LW 0x10 is unchanged.
REQ-034 LATENCY=4 with rsp_ready held low for 3 cycles -> rsp_valid first high 4 cycles after acceptance; rsp_rdata stable throughout; req_ready = 0 until the cycle after the rsp handshake.
REQ-035 SW 0x12345678 at 0x20 accepted, then reset asserted during WAIT -> no rsp_valid; after reset, LW 0x20 -> 0x12345678.
REQ-036 Reset and req_valid high in the same cycle as an SW 0x1 at 0x24 -> no commit; LW 0x24 returns the prior value.

Source files
------------

// File: rtl/dmem_responder_if.sv
// dmem_responder_if: request/response handshake bundle between an initiator and a data memory responder
interface dmem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );
  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/dmem_responder.sv
// dmem_responder: single-outstanding RISC-V load/store memory with fixed response latency
module dmem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 1
) (
  input  logic       clk,
  input  logic       reset,
  dmem_responder_if.slave bus
);
  localparam int AW = $clog2(4 * DEPTH_WORDS);
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          err_q, err_d;
  logic [31:0]   mem [DEPTH_WORDS];
  logic [AW-3:0] idx;
  logic [2:0]    f3;
  logic [31:0]   word, sh, ld, wd;
  logic [15:0]   h;
  logic [3:0]    be;
  logic          err, acc, we;
  // decode the presented request: load extraction, error detection, store lanes
  always_comb begin
    f3   = bus.req_funct3;
    idx  = bus.req_addr[AW-1:2];
    word = mem[idx];
    sh   = word >> {bus.req_addr[1:0], 3'b000};
    h    = bus.req_addr[1] ? word[31:16] : word[15:0];
    ld   = f3[1] ? word : f3[0] ? {{16{h[15] & ~f3[2]}}, h} : {{24{sh[7] & ~f3[2]}}, sh[7:0]};
    err  = (bus.req_addr >= 32'(4 * DEPTH_WORDS)) || (f3[1:0] == 2'b11) ||
           (f3[1] && (f3[2] || bus.req_addr[1:0] != 2'b00)) ||
           (f3[1:0] == 2'b01 && bus.req_addr[0]) || (bus.req_we && f3[2]);
    acc  = state_q == IDLE && bus.req_valid && !reset;
    we   = acc && bus.req_we && !err;
    be   = f3[1] ? 4'hf : f3[0] ? (bus.req_addr[1] ? 4'hc : 4'h3) : 4'b0001 << bus.req_addr[1:0];
    wd   = f3[1] ? bus.req_wdata : f3[0] ? {2{bus.req_wdata[15:0]}} : {4{bus.req_wdata[7:0]}};
  end
  // next-state: capture on acceptance, count down the wait, release on response handshake
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    if (state_q == IDLE && bus.req_valid) begin
      state_d = LATENCY > 1 ? WAIT : RESP;
      cnt_d   = 4'(LATENCY - 1);
      rdata_d = (err || bus.req_we) ? '0 : ld;
      err_d   = err;
    end else if (state_q == WAIT) begin
      cnt_d   = cnt_q - 4'd1;
      state_d = cnt_q == 4'd1 ? RESP : WAIT;
    end else if (state_q == RESP && bus.rsp_ready) begin
      state_d = IDLE;
    end
  end
  // state and response registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end
  // byte-lane store commit on the acceptance edge; contents survive reset
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++)
      if (we && be[i]) mem[idx][8*i +: 8] <= wd[8*i +: 8];
  end
  assign bus.req_ready = state_q == IDLE && !reset;
  assign bus.rsp_valid = state_q == RESP && !reset;
  assign bus.rsp_rdata = reset ? '0 : rdata_q;
  assign bus.rsp_err   = err_q && !reset;
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed vector bench for dmem_responder at LATENCY 1 and 4
module tb_dmem_responder;
  logic        clk = 0;
  logic        reset = 1;
  logic        sel = 0;
  logic        req_valid = 0, req_we = 0, rsp_ready = 0;
  logic [2:0]  req_funct3 = 0;
  logic [31:0] req_addr = 0, req_wdata = 0;
  logic        rdy, vld, err;
  logic [31:0] rdata;
  int          n_chk = 0, n_fail = 0;
  dmem_responder_if ia ();
  dmem_responder_if ib ();
  assign ia.req_valid = req_valid && !sel;
  assign ib.req_valid = req_valid && sel;
  assign ia.rsp_ready = rsp_ready && !sel;
  assign ib.rsp_ready = rsp_ready && sel;
  assign ia.req_we = req_we;
  assign ib.req_we = req_we;
  assign ia.req_funct3 = req_funct3;
  assign ib.req_funct3 = req_funct3;
  assign ia.req_addr = req_addr;
  assign ib.req_addr = req_addr;
  assign ia.req_wdata = req_wdata;
  assign ib.req_wdata = req_wdata;
  assign rdy   = sel ? ib.req_ready : ia.req_ready;
  assign vld   = sel ? ib.rsp_valid : ia.rsp_valid;
  assign err   = sel ? ib.rsp_err   : ia.rsp_err;
  assign rdata = sel ? ib.rsp_rdata : ia.rsp_rdata;
  dmem_responder #(.DEPTH_WORDS(1024), .LATENCY(1)) u_l1 (.clk(clk), .reset(reset), .bus(ia));
  dmem_responder #(.DEPTH_WORDS(1024), .LATENCY(4)) u_l4 (.clk(clk), .reset(reset), .bus(ib));
  always #5 clk = ~clk;
  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] rd;
    logic        err;
  } vec_t;
  vec_t v[20];
  function automatic void chk(string nm, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endfunction
  task automatic xact(input logic we, input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wd,
                      input int hold, input logic [31:0] exp_d, input logic exp_e, input int exp_lat, input string nm);
    int n;
    logic [31:0] d0;
    @(negedge clk);
    req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd; req_valid = 1; rsp_ready = 0;
    n = 0;
    while (!rdy && n < 20) begin @(negedge clk); n++; end
    chk({nm, "/ready"}, 32'(rdy), 32'd1);
    @(posedge clk); #1;
    req_valid = 0;
    n = 1;
    while (!vld && n < 40) begin @(posedge clk); #1; n++; end
    chk({nm, "/latency"}, 32'(n), 32'(exp_lat));
    chk({nm, "/rdata"}, rdata, exp_d);
    chk({nm, "/err"}, 32'(err), 32'(exp_e));
    chk({nm, "/busy"}, 32'(rdy), 32'd0);
    d0 = rdata;
    for (int k = 0; k < hold; k++) begin
      @(posedge clk); #1;
      chk({nm, "/hold_valid"}, 32'(vld), 32'd1);
      chk({nm, "/hold_rdata"}, rdata, d0);
      chk({nm, "/hold_busy"}, 32'(rdy), 32'd0);
    end
    rsp_ready = 1;
    @(posedge clk); #1;
    rsp_ready = 0;
    chk({nm, "/done_ready"}, 32'(rdy), 32'd1);
    chk({nm, "/done_valid"}, 32'(vld), 32'd0);
  endtask
  initial begin
    v[0]  = '{1, 3'b010, 32'h10,       32'hDEADBEEF, 32'h0,        0};
    v[1]  = '{0, 3'b010, 32'h10,       32'h0,        32'hDEADBEEF, 0};
    v[2]  = '{1, 3'b000, 32'h11,       32'h7F,       32'h0,        0};
    v[3]  = '{0, 3'b000, 32'h13,       32'h0,        32'hFFFFFFDE, 0};
    v[4]  = '{0, 3'b100, 32'h13,       32'h0,        32'h000000DE, 0};
    v[5]  = '{0, 3'b001, 32'h10,       32'h0,        32'h00007FEF, 0};
    v[6]  = '{0, 3'b010, 32'h10,       32'h0,        32'hDEAD7FEF, 0};
    v[7]  = '{0, 3'b010, 32'h12,       32'h0,        32'h0,        1};
    v[8]  = '{1, 3'b001, 32'h11,       32'hFFFF,     32'h0,        1};
    v[9]  = '{0, 3'b010, 32'h1000,     32'h0,        32'h0,        1};
    v[10] = '{0, 3'b011, 32'h10,       32'h0,        32'h0,        1};
    v[11] = '{1, 3'b011, 32'h10,       32'h0,        32'h0,        1};
    v[12] = '{1, 3'b100, 32'h10,       32'h0,        32'h0,        1};
    v[13] = '{1, 3'b010, 32'h80000010, 32'h0,        32'h0,        1};
    v[14] = '{0, 3'b010, 32'h10,       32'h0,        32'hDEAD7FEF, 0};
    v[15] = '{0, 3'b001, 32'h12,       32'h0,        32'hFFFFDEAD, 0};
    v[16] = '{0, 3'b101, 32'h12,       32'h0,        32'h0000DEAD, 0};
    v[17] = '{1, 3'b001, 32'h12,       32'h1234,     32'h0,        0};
    v[18] = '{1, 3'b010, 32'hFFC,      32'hAABBCCDD, 32'h0,        0};
    v[19] = '{0, 3'b000, 32'hFFD,      32'h0,        32'hFFFFFFCC, 0};
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready_a", 32'(ia.req_ready), 32'd0);
    chk("rst_valid_a", 32'(ia.rsp_valid), 32'd0);
    chk("rst_rdata_a", ia.rsp_rdata, 32'd0);
    chk("rst_err_a", 32'(ia.rsp_err), 32'd0);
    chk("rst_ready_b", 32'(ib.req_ready), 32'd0);
    chk("rst_valid_b", 32'(ib.rsp_valid), 32'd0);
    @(negedge clk);
    reset = 0;
    @(posedge clk); #1;
    chk("post_rst_ready_a", 32'(ia.req_ready), 32'd1);
    chk("post_rst_ready_b", 32'(ib.req_ready), 32'd1);
    for (int i = 0; i < 20; i++)
      xact(v[i].we, v[i].f3, v[i].addr, v[i].wd, i % 3, v[i].rd, v[i].err, 1, $sformatf("vec%0d", i));
    xact(0, 3'b010, 32'h10,  32'h0, 0, 32'h1234_7FEF, 0, 1, "lw10_after_sh");
    xact(0, 3'b010, 32'hFFC, 32'h0, 0, 32'hAABBCCDD, 0, 1, "lw_top");
    sel = 1;
    xact(1, 3'b010, 32'h40, 32'h55AA33CC, 0, 32'h0, 0, 4, "l4_sw40");
    xact(0, 3'b010, 32'h40, 32'h0, 3, 32'h55AA33CC, 0, 4, "l4_lw40_hold");
    xact(0, 3'b000, 32'h43, 32'h0, 1, 32'h00000055, 0, 4, "l4_lb43");
    xact(0, 3'b010, 32'h42, 32'h0, 2, 32'h0, 1, 4, "l4_err");
    @(negedge clk);
    req_we = 1; req_funct3 = 3'b010; req_addr = 32'h20; req_wdata = 32'h12345678; req_valid = 1;
    @(posedge clk); #1;
    req_valid = 0;
    chk("wait_busy", 32'(rdy), 32'd0);
    @(negedge clk);
    reset = 1;
    @(posedge clk); #1;
    chk("wait_rst_valid", 32'(vld), 32'd0);
    chk("wait_rst_ready", 32'(rdy), 32'd0);
    @(negedge clk);
    reset = 0;
    begin
      int seen = 0;
      for (int k = 0; k < 6; k++) begin
        @(posedge clk); #1;
        if (vld) seen++;
      end
      chk("dropped_rsp", 32'(seen), 32'd0);
    end
    chk("ready_after_wait_rst", 32'(rdy), 32'd1);
    xact(0, 3'b010, 32'h20, 32'h0, 0, 32'h12345678, 0, 4, "lw20_kept");
    xact(1, 3'b010, 32'h24, 32'h0A0B0C0D, 0, 32'h0, 0, 4, "sw24");
    @(negedge clk);
    req_we = 1; req_funct3 = 3'b010; req_addr = 32'h24; req_wdata = 32'h1; req_valid = 1; reset = 1;
    @(posedge clk); #1;
    chk("rst_acc_ready", 32'(rdy), 32'd0);
    @(negedge clk);
    req_valid = 0; reset = 0;
    @(posedge clk); #1;
    chk("rst_acc_ready_after", 32'(rdy), 32'd1);
    chk("rst_acc_valid", 32'(vld), 32'd0);
    xact(0, 3'b010, 32'h24, 32'h0, 0, 32'h0A0B0C0D, 0, 4, "lw24_no_commit");
    sel = 0;
    xact(0, 3'b010, 32'h10, 32'h0, 0, 32'h1234_7FEF, 0, 1, "l1_array_kept");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
